// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin share of the interconnect data port among
// NUM_MASTERS requesters, with a bounded bus lock for read-modify-write and
// a fixed one-cycle read-return path.
module data_bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int MAX_LOCK    = 8
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic [NUM_MASTERS-1:0]    i_req,
   input  logic [NUM_MASTERS-1:0]    i_lock,
   input  logic [NUM_MASTERS-1:0]    i_we,
   input  logic [32*NUM_MASTERS-1:0] i_addr,
   input  logic [32*NUM_MASTERS-1:0] i_wd,
   output logic [NUM_MASTERS-1:0]    o_gnt,
   output logic [NUM_MASTERS-1:0]    o_rvalid,
   output logic [31:0]               o_rd,
   output logic                      o_we_m,
   output logic [31:0]               o_addr_m,
   output logic [31:0]               o_wd_m,
   input  logic [31:0]               i_rd_m
);
   localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

   lock_state_t            r_state, w_state_nxt;
   logic [PTR_W-1:0]       r_ptr, w_ptr_nxt;
   logic [PTR_W-1:0]       r_owner, w_owner_nxt;
   logic [CNT_W-1:0]       r_lock_cnt, w_lock_cnt_nxt;
   logic [NUM_MASTERS-1:0] r_rvalid;
   logic [PTR_W-1:0]       w_winner, w_cand;
   logic                   w_any_gnt;
   logic [31:0]            w_addr_arr [NUM_MASTERS];
   logic [31:0]            w_wd_arr   [NUM_MASTERS];

   for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
      assign w_addr_arr[g] = i_addr[32*g +: 32];
      assign w_wd_arr[g]   = i_wd[32*g +: 32];
   end

   // Pick the winner: the lock owner exclusively, else first requester from r_ptr
   always_comb begin
      w_any_gnt = 1'b0;
      w_winner  = '0;
      w_cand    = '0;
      if (!i_reset) begin
         if (r_state == LOCKED) begin
            w_winner  = r_owner;
            w_any_gnt = i_req[r_owner];
         end else begin
            for (int k = 0; k < NUM_MASTERS; k++) begin
               w_cand = PTR_W'((int'(r_ptr) + k) % NUM_MASTERS);
               if (!w_any_gnt && i_req[w_cand]) begin
                  w_any_gnt = 1'b1;
                  w_winner  = w_cand;
               end
            end
         end
      end
   end

   // Drive the winner's transaction onto the interconnect; all zero when idle
   always_comb begin
      o_gnt    = '0;
      o_we_m   = 1'b0;
      o_addr_m = '0;
      o_wd_m   = '0;
      if (w_any_gnt) begin
         o_gnt[w_winner] = 1'b1;
         o_we_m          = i_we[w_winner];
         o_addr_m        = w_addr_arr[w_winner];
         o_wd_m          = w_wd_arr[w_winner];
      end
   end

   // Next pointer and lock FSM; the grant that releases a lock is still exclusive
   // to the owner, so the count limit is applied to the grant being issued now
   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_lock_cnt_nxt = r_lock_cnt;
      w_ptr_nxt      = r_ptr;
      if (w_any_gnt)
         w_ptr_nxt = (w_winner == PTR_W'(NUM_MASTERS - 1)) ? '0 : w_winner + 1'b1;
      case (r_state)
         UNLOCKED: begin
            if (w_any_gnt && i_lock[w_winner] && (MAX_LOCK > 1)) begin
               w_state_nxt    = LOCKED;
               w_owner_nxt    = w_winner;
               w_lock_cnt_nxt = CNT_W'(1);
            end
         end
         LOCKED: begin
            if (!w_any_gnt || !i_lock[r_owner] ||
                (r_lock_cnt >= CNT_W'(MAX_LOCK - 1))) begin
               w_state_nxt    = UNLOCKED;
               w_lock_cnt_nxt = '0;
            end else begin
               w_lock_cnt_nxt = r_lock_cnt + 1'b1;
            end
         end
         default: w_state_nxt = UNLOCKED;
      endcase
   end

   // State registers; a read granted this cycle returns its data next cycle
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= UNLOCKED;
         r_owner    <= '0;
         r_lock_cnt <= '0;
         r_ptr      <= '0;
         r_rvalid   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_ptr      <= w_ptr_nxt;
         r_rvalid   <= o_gnt & ~i_we;
      end
   end

   // Masking with reset kills a return belonging to a read issued just before reset
   assign o_rvalid = r_rvalid & {NUM_MASTERS{~i_reset}};
   assign o_rd     = i_rd_m;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: a vector table for the single-cycle behaviour,
// followed by hand-written sequences for lock, forced release and reset.
module tb_data_bus_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req, lock, we;
   logic [31:0] a0, a1, w0, w1;
   logic [1:0]  gnt, rvalid;
   logic [31:0] rd, addr_m, wd_m, rd_m;
   logic        we_m;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   data_bus_arbiter #(.NUM_MASTERS(2), .MAX_LOCK(8)) dut (
      .i_clk(clk), .i_reset(reset), .i_req(req), .i_lock(lock), .i_we(we),
      .i_addr({a1, a0}), .i_wd({w1, w0}), .o_gnt(gnt), .o_rvalid(rvalid),
      .o_rd(rd), .o_we_m(we_m), .o_addr_m(addr_m), .o_wd_m(wd_m), .i_rd_m(rd_m)
   );

   // Synchronous slave: unwritten words read as C0DE_0000 | word index
   logic [31:0] mem [256];
   bit   [255:0] wvalid = '0;
   always @(posedge clk) begin
      if (we_m) begin
         mem[addr_m[9:2]]    <= wd_m;
         wvalid[addr_m[9:2]] <= 1'b1;
      end
      rd_m <= wvalid[addr_m[9:2]] ? mem[addr_m[9:2]] : (32'hC0DE_0000 | 32'(addr_m[9:2]));
   end

   typedef struct {
      logic        rst;
      logic [1:0]  req, lock, we;
      logic [31:0] a0, a1, w0, w1;
      logic [1:0]  gnt, rv;
      logic        wem;
      logic [31:0] am, wm, rd;
      logic        crd;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic [1:0] rq, input logic [1:0] lk,
                        input logic [1:0] w, input logic [31:0] ad0, input logic [31:0] ad1);
      @(posedge clk); #1;
      reset = r; req = rq; lock = lk; we = w; a0 = ad0; a1 = ad1; w0 = '0; w1 = '0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; req = '0; lock = '0; we = '0;
      a0 = '0; a1 = '0; w0 = '0; w1 = '0;

      //          rst req    lock   we     a0            a1            w0            w1             gnt    rv     wem  am            wm            rd            crd
      vecs.push_back('{1'b1, 2'b11, 2'b00, 2'b11, 32'h1000,     32'h2000,     32'hAAAA,     32'hBBBB,      2'b00, 2'b00, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0});
      vecs.push_back('{1'b1, 2'b11, 2'b00, 2'b11, 32'h1000,     32'h2000,     32'hAAAA,     32'hBBBB,      2'b00, 2'b00, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0});
      vecs.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,         2'b00, 2'b00, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0});
      vecs.push_back('{1'b0, 2'b01, 2'b00, 2'b00, 32'h1004,     32'h0,        32'h0,        32'h0,         2'b01, 2'b00, 1'b0, 32'h1004,     32'h0,        32'h0,        1'b0});
      vecs.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,         2'b00, 2'b01, 1'b0, 32'h0,        32'h0,        32'hC0DE0001, 1'b1});
      vecs.push_back('{1'b0, 2'b10, 2'b00, 2'b00, 32'h0,        32'h100C,     32'h0,        32'h0,         2'b10, 2'b00, 1'b0, 32'h100C,     32'h0,        32'h0,        1'b0});
      vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 32'h1008,     32'h1010,     32'h0,        32'h0,         2'b01, 2'b10, 1'b0, 32'h1008,     32'h0,        32'hC0DE0003, 1'b1});
      vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 32'h1008,     32'h1010,     32'h0,        32'h0,         2'b10, 2'b01, 1'b0, 32'h1010,     32'h0,        32'hC0DE0002, 1'b1});
      vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 32'h1008,     32'h1010,     32'h0,        32'h0,         2'b01, 2'b10, 1'b0, 32'h1008,     32'h0,        32'hC0DE0004, 1'b1});
      vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b00, 32'h1008,     32'h1010,     32'h0,        32'h0,         2'b10, 2'b01, 1'b0, 32'h1010,     32'h0,        32'hC0DE0002, 1'b1});
      vecs.push_back('{1'b0, 2'b10, 2'b00, 2'b10, 32'h0,        32'h2000,     32'h0,        32'hDEAD,      2'b10, 2'b10, 1'b1, 32'h2000,     32'hDEAD,     32'hC0DE0004, 1'b1});
      vecs.push_back('{1'b0, 2'b01, 2'b00, 2'b00, 32'h2000,     32'h0,        32'h1111,     32'h0,         2'b01, 2'b00, 1'b0, 32'h2000,     32'h1111,     32'h0,        1'b0});
      vecs.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,         2'b00, 2'b01, 1'b0, 32'h0,        32'h0,        32'hDEAD,     1'b1});
      vecs.push_back('{1'b0, 2'b11, 2'b00, 2'b01, 32'h1018,     32'h1014,     32'h3333,     32'h2222,      2'b10, 2'b00, 1'b0, 32'h1014,     32'h2222,     32'h0,        1'b0});
      vecs.push_back('{1'b0, 2'b01, 2'b00, 2'b01, 32'h1018,     32'h0,        32'h3333,     32'h0,         2'b01, 2'b10, 1'b1, 32'h1018,     32'h3333,     32'hC0DE0005, 1'b1});
      vecs.push_back('{1'b0, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        32'h0,        32'h0,         2'b00, 2'b00, 1'b0, 32'h0,        32'h0,        32'h0,        1'b0});

      foreach (vecs[i]) begin
         @(posedge clk); #1;
         reset = vecs[i].rst; req = vecs[i].req; lock = vecs[i].lock; we = vecs[i].we;
         a0 = vecs[i].a0; a1 = vecs[i].a1; w0 = vecs[i].w0; w1 = vecs[i].w1;
         @(negedge clk);
         check($sformatf("vec%0d gnt", i),    32'(gnt),    32'(vecs[i].gnt));
         check($sformatf("vec%0d rvalid", i), 32'(rvalid), 32'(vecs[i].rv));
         check($sformatf("vec%0d we_m", i),   32'(we_m),   32'(vecs[i].wem));
         check($sformatf("vec%0d addr_m", i), addr_m,      vecs[i].am);
         check($sformatf("vec%0d wd_m", i),   wd_m,        vecs[i].wm);
         if (vecs[i].crd) check($sformatf("vec%0d rd", i), rd, vecs[i].rd);
      end

      // Lock held 3 cycles then dropped: 4 grants to master0, master1 on the 5th
      drive(1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
      for (int c = 1; c <= 5; c++) begin
         drive(1'b0, 2'b11, (c <= 3) ? 2'b01 : 2'b00, 2'b00, 32'h1008, 32'h100C);
         check($sformatf("lock c%0d gnt", c), 32'(gnt), (c <= 4) ? 32'h1 : 32'h2);
      end

      // Owner dropping req releases the lock on the same edge
      drive(1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
      drive(1'b0, 2'b01, 2'b01, 2'b00, 32'h1008, 32'h100C);
      check("lockreq c1 gnt", 32'(gnt), 32'h1);
      drive(1'b0, 2'b10, 2'b00, 2'b00, 32'h1008, 32'h100C);
      check("lockreq c2 gnt", 32'(gnt), 32'h0);
      drive(1'b0, 2'b10, 2'b00, 2'b00, 32'h1008, 32'h100C);
      check("lockreq c3 gnt", 32'(gnt), 32'h2);

      // Forced release after MAX_LOCK grants, then master0 re-wins and relocks
      drive(1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
      for (int c = 1; c <= 12; c++) begin
         drive(1'b0, 2'b11, 2'b01, 2'b00, 32'h1008, 32'h100C);
         check($sformatf("maxlock c%0d gnt", c), 32'(gnt), (c == 9) ? 32'h2 : 32'h1);
      end

      // Reset one cycle after a locked read by master1: no rvalid, lock and ptr cleared
      drive(1'b1, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
      drive(1'b0, 2'b10, 2'b10, 2'b00, 32'h1008, 32'h1004);
      check("rst c1 gnt", 32'(gnt), 32'h2);
      drive(1'b1, 2'b11, 2'b00, 2'b00, 32'h1008, 32'h1004);
      check("rst c2 gnt", 32'(gnt), 32'h0);
      check("rst c2 rvalid", 32'(rvalid), 32'h0);
      drive(1'b0, 2'b11, 2'b00, 2'b00, 32'h1008, 32'h1004);
      check("rst c3 gnt", 32'(gnt), 32'h1);
      check("rst c3 rvalid", 32'(rvalid), 32'h0);
      drive(1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0);
      check("rst c4 rvalid", 32'(rvalid), 32'h1);
      check("rst c4 rd", rd, 32'hC0DE0002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
